cfg_serial_loader: RTL and testbench

- Wishbone slave that serialises a 32-bit configuration word onto a two-wire clock/data interface.
- Sits directly upstream of the configuration shift register in the analog wrapper; drives that register's clk and din pins.
- Lets the management SoC load SSTL driver configuration without bit-banging GPIOs.
- Raises an interrupt when a transfer completes.

---
 rtl/cfg_loader_pkg.sv | 29 ++
 rtl/cfg_half_period_timer.sv | 27 ++
 rtl/cfg_serial_loader.sv | 184 ++++++++++++++++++
 tb/tb_cfg_serial_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared register map, field positions and FSM state type for the serial config loader.
package cfg_loader_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    localparam int unsigned CTRL_START     = 0;
    localparam int unsigned CTRL_IE        = 1;
    localparam int unsigned CTRL_DIV_LSB   = 8;
    localparam int unsigned DIV_W          = 8;
    localparam int unsigned CTRL_LEN_LSB   = 16;
    localparam int unsigned LEN_W          = 5;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned CNT_W          = 8;

    localparam int unsigned BITCNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/cfg_half_period_timer.sv
// Half-period down-counter: reloads on phase entry, flags expiry when it reaches zero.
module cfg_half_period_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_c_o
);

    logic [W-1:0] count_q;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire_c_o = (count_q == '0);

endmodule

// File: rtl/cfg_serial_loader.sv
// Wishbone slave that shifts a 32-bit config word MSB-first onto a clk/din pair.
module cfg_serial_loader
    import cfg_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cfg_clk_o,
    output logic        cfg_din_o,
    output logic        cfg_busy_o,
    output logic        irq_o
);

    state_e                 state_q;
    logic [31:0]            data_q, data_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   ie_q, ie_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [31:0]            shift_q;
    logic [BITCNT_W-1:0]    bitcnt_q;
    logic                   ack_q, clk_q, din_q, busy_q, irq_q;
    logic [31:0]            rdat_q;

    logic                   acc_c, wr_c, start_c, expire_c, load_c, last_bit_c;
    logic [31:0]            rdata_c;

    // Address decode: one access per ack, never while an ack is pending.
    assign acc_c = wbs_cyc_i & wbs_stb_i & ~ack_q &
                   (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_c  = acc_c & wbs_we_i;

    // Register file next-state, including busy write protection and FINISH side effects.
    always_comb begin
        data_d  = data_q;
        div_d   = div_q;
        len_d   = len_q;
        ie_d    = ie_q;
        done_d  = done_q;
        count_d = count_q;
        start_c = 1'b0;
        if (wr_c) begin
            case (wbs_adr_i[3:0])
                OFF_DATA: begin
                    if (!busy_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wbs_sel_i[b]) data_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                        end
                    end
                end
                OFF_CTRL: begin
                    if (wbs_sel_i[0]) ie_d = wbs_dat_i[CTRL_IE];
                    if (!busy_q) begin
                        if (wbs_sel_i[1]) div_d = wbs_dat_i[CTRL_DIV_LSB +: DIV_W];
                        if (wbs_sel_i[2]) len_d = wbs_dat_i[CTRL_LEN_LSB +: LEN_W];
                        start_c = wbs_sel_i[0] & wbs_dat_i[CTRL_START];
                    end
                end
                OFF_STATUS: begin
                    if (wbs_sel_i[0] && wbs_dat_i[STAT_DONE]) done_d = 1'b0;
                end
                default: ;
            endcase
        end
        // Completion beats a simultaneous clear.
        if (state_q == FINISH) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
        end
    end

    // Read mux over the current register contents.
    always_comb begin
        rdata_c = '0;
        case (wbs_adr_i[3:0])
            OFF_DATA:   rdata_c = data_q;
            OFF_CTRL:   rdata_c = {11'b0, len_q, div_q, 6'b0, ie_q, 1'b0};
            OFF_STATUS: rdata_c = {16'b0, count_q, 6'b0, done_q, busy_q};
            default:    rdata_c = '0;
        endcase
    end

    assign last_bit_c = (bitcnt_q == BITCNT_W'(1));

    // Reload the half-period timer on every entry into LOW or HIGH.
    assign load_c = ((state_q == IDLE) & start_c) |
                    ((state_q == LOW)  & expire_c) |
                    ((state_q == HIGH) & expire_c & ~last_bit_c);

    cfg_half_period_timer #(.W(DIV_W)) u_timer (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_ni),
        .load_i     (load_c),
        .load_val_i (div_d),
        .expire_c_o (expire_c)
    );

    // Bus response, register file and serialiser FSM with registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            data_q   <= '0;
            div_q    <= DIV_RESET;
            len_q    <= '0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            clk_q    <= 1'b0;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q   <= acc_c;
            rdat_q  <= (acc_c && !wbs_we_i) ? rdata_c : 32'h0;
            data_q  <= data_d;
            div_q   <= div_d;
            len_q   <= len_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            count_q <= count_d;
            irq_q   <= done_d & ie_d;
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_q  <= LOW;
                        shift_q  <= data_q;
                        bitcnt_q <= BITCNT_W'(len_d) + BITCNT_W'(1);
                        clk_q    <= 1'b0;
                        din_q    <= data_q[31];
                        busy_q   <= 1'b1;
                    end
                end
                LOW: begin
                    if (expire_c) begin
                        state_q <= HIGH;
                        clk_q   <= 1'b1;
                    end
                end
                HIGH: begin
                    if (expire_c) begin
                        shift_q  <= {shift_q[30:0], 1'b0};
                        bitcnt_q <= bitcnt_q - BITCNT_W'(1);
                        clk_q    <= 1'b0;
                        if (last_bit_c) begin
                            state_q <= FINISH;
                            din_q   <= 1'b0;
                        end else begin
                            state_q <= LOW;
                            din_q   <= shift_q[30];
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdat_q;
    assign cfg_clk_o  = clk_q;
    assign cfg_din_o  = din_q;
    assign cfg_busy_o = busy_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed bench for cfg_serial_loader: register access, serial waveform and reset behaviour.
module tb_cfg_serial_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_UNM  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        cfg_clk, cfg_din, cfg_busy, irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cfg_serial_loader #(.BASE_ADDR(BASE), .DIV_RESET(8'd3)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .cfg_clk_o  (cfg_clk),
        .cfg_din_o  (cfg_din),
        .cfg_busy_o (cfg_busy),
        .irq_o      (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        r = rdat;
        if (!ack) check_eq("ack_timeout", 32'd0, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, s, r);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_xfer(1'b0, a, 32'h0, 4'hF, r);
    endtask

    // Samples once per cycle while busy; collects din at each cfg_clk rising edge.
    task automatic capture(input int limit, input int period, output int busy_n, output int edges,
                           output logic [31:0] bits, output int gap_err, output int irq_seen);
        logic prev;
        int   last;
        busy_n = 0; edges = 0; bits = '0; gap_err = 0; irq_seen = 0; prev = 1'b0; last = 0;
        while (cfg_busy && busy_n < limit) begin
            busy_n++;
            if (irq) irq_seen++;
            if (cfg_clk && !prev) begin
                bits = {bits[30:0], cfg_din};
                edges++;
                if (edges > 1 && (busy_n - last) != period) gap_err++;
                last = busy_n;
            end
            prev = cfg_clk;
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] r, bits;
    int busy_n, edges, gap_err, irq_seen, n;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values after a one-cycle reset pulse
        wb_write(A_DATA, 32'hA5A5_0F0F, 4'hF);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        check_eq("rst_clk", 32'(cfg_clk), 32'd0);
        check_eq("rst_din", 32'(cfg_din), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        wb_read(A_DATA, r); check_eq("rst_data", r, 32'h0);
        wb_read(A_CTRL, r); check_eq("rst_ctrl", r, 32'h0000_0300);
        wb_read(A_STAT, r); check_eq("rst_status", r, 32'h0);

        // Unmapped offset acks and reads zero
        wb_write(A_UNM, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_UNM, r); check_eq("unmapped_rd", r, 32'h0);
        wb_read(A_DATA, r); check_eq("unmapped_no_side", r, 32'h0);

        // Full 32-bit load, DIV=1
        wb_write(A_DATA, 32'hDEAD_BEEF, 4'hF);
        wb_write(A_CTRL, 32'h001F_0101, 4'hF);
        capture(400, 4, busy_n, edges, bits, gap_err, irq_seen);
        check_eq("full_busy", 32'(busy_n), 32'd129);
        check_eq("full_edges", 32'(edges), 32'd32);
        check_eq("full_bits", bits, 32'hDEAD_BEEF);
        check_eq("full_gap", 32'(gap_err), 32'd0);
        check_eq("full_clk_idle", 32'(cfg_clk), 32'd0);
        wb_read(A_STAT, r); check_eq("full_status", r, 32'h0000_0102);
        wb_read(A_DATA, r); check_eq("full_data_kept", r, 32'hDEAD_BEEF);

        // Short transfer with interrupt, DIV=0
        wb_write(A_STAT, 32'h2, 4'h1);
        wb_write(A_DATA, 32'h8100_0000, 4'hF);
        wb_write(A_CTRL, 32'h0007_0003, 4'hF);
        capture(100, 2, busy_n, edges, bits, gap_err, irq_seen);
        check_eq("short_busy", 32'(busy_n), 32'd17);
        check_eq("short_edges", 32'(edges), 32'd8);
        check_eq("short_bits", bits, 32'h0000_0081);
        check_eq("short_gap", 32'(gap_err), 32'd0);
        check_eq("short_irq_early", 32'(irq_seen), 32'd0);
        check_eq("short_irq", 32'(irq), 32'd1);
        wb_read(A_STAT, r); check_eq("short_status", r, 32'h0000_0202);
        wb_write(A_STAT, 32'h2, 4'h1);
        check_eq("irq_cleared", 32'(irq), 32'd0);
        wb_read(A_STAT, r); check_eq("done_cleared", r, 32'h0000_0200);

        // Busy protection: writes during a transfer must not disturb it
        wb_write(A_DATA, 32'hA500_0000, 4'hF);
        wb_write(A_CTRL, 32'h0007_0101, 4'hF);
        fork
            capture(200, 4, busy_n, edges, bits, gap_err, irq_seen);
            begin
                wb_write(A_DATA, 32'h0, 4'hF);
                wb_write(A_CTRL, 32'h0003_0001, 4'hF);
            end
        join
        check_eq("prot_busy", 32'(busy_n), 32'd33);
        check_eq("prot_edges", 32'(edges), 32'd8);
        check_eq("prot_bits", bits, 32'h0000_00A5);
        check_eq("prot_gap", 32'(gap_err), 32'd0);
        wb_read(A_DATA, r); check_eq("prot_data", r, 32'hA500_0000);
        wb_read(A_CTRL, r); check_eq("prot_ctrl", r, 32'h0007_0100);
        wb_read(A_STAT, r); check_eq("prot_status", r, 32'h0000_0302);

        // Byte selects
        wb_write(A_DATA, 32'h0, 4'hF);
        wb_write(A_DATA, 32'h1122_3344, 4'b0101);
        wb_read(A_DATA, r); check_eq("byte_sel", r, 32'h0022_0044);

        // Mid-transfer reset after the 5th rising edge, then a clean full transfer
        wb_write(A_DATA, 32'hDEAD_BEEF, 4'hF);
        wb_write(A_CTRL, 32'h001F_0101, 4'hF);
        edges = 0; n = 0;
        begin
            logic prev;
            prev = cfg_clk;
            while (edges < 5 && n < 200) begin
                @(posedge clk); #1;
                n++;
                if (cfg_clk && !prev) edges++;
                prev = cfg_clk;
            end
        end
        check_eq("mid_edges", 32'(edges), 32'd5);
        check_eq("mid_clk_high", 32'(cfg_clk), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_clk", 32'(cfg_clk), 32'd0);
        check_eq("mid_rst_din", 32'(cfg_din), 32'd0);
        check_eq("mid_rst_busy", 32'(cfg_busy), 32'd0);
        rst_n = 1'b1;
        wb_write(A_DATA, 32'hDEAD_BEEF, 4'hF);
        wb_write(A_CTRL, 32'h001F_0101, 4'hF);
        capture(400, 4, busy_n, edges, bits, gap_err, irq_seen);
        check_eq("post_busy", 32'(busy_n), 32'd129);
        check_eq("post_edges", 32'(edges), 32'd32);
        check_eq("post_bits", bits, 32'hDEAD_BEEF);
        wb_read(A_STAT, r); check_eq("post_status", r, 32'h0000_0102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
